fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Upstream neighbour of the instruction memory: owns the PC and drives the word address into it.
//  Reads the returned word in the same cycle and registers it, with its PC, toward decode.
//  Resolves JAL / JR / EXIT at fetch using an internal return-address stack (RAS).
//  Accepts late redirects from execute and honours decode stalls.
// PARAMETERS
//  ADDR_W      32  PC / address width (word-addressed: PC+1 = next instruction)
//  RESET_PC    0   PC value after reset
//  IMEM_WORDS  11  valid instruction words; PC >= IMEM_WORDS is a fetch fault
//  RAS_DEPTH   4   return-address stack entries (power of 2)
// PORTS
//  Clk          in   1       clock, all state updates on posedge
//  Rst          in   1       synchronous, active-high reset
//  Addr         out  ADDR_W  word address to instruction memory (= PC register, combinational)
//  InstrIn      in   32      word returned by instruction memory for Addr, same cycle
//  Stall        in   1       decode cannot accept; hold all state
//  Redirect     in   1       execute-stage taken branch; flush and load RedirectPC
//  RedirectPC   in   ADDR_W  redirect target
//  InstrOut     out  32      registered instruction to decode
//  InstrPC      out  ADDR_W  PC of InstrOut
//  InstrValid   out  1       InstrOut is a real instruction
//  LinkAddr     out  ADDR_W  PC+1 of InstrOut (for JAL $ra writeback)
//  Halted       out  1       fetch stopped (EXIT or fault); only Rst clears
//  Fault        out  1       sticky: JR on empty RAS or PC out of range
//  RasOverflow  out  1       sticky: push onto full RAS
// BEHAVIOUR
//  Reset: PC=RESET_PC. InstrOut, InstrPC and LinkAddr = 0. InstrValid=0, Halted=0, Fault=0, RasOverflow=0. RAS emptied.
//  Rst asserted mid-operation wins over every other input in that cycle.
//  FSM: RUN -> HALT only. HALT is left only by Rst.
//  In HALT: PC frozen, InstrValid=0, Redirect/Stall ignored.
//  Decode fields: op=InstrIn[31:26], rs=[25:21], imm=[10:0].
//  Priority in RUN, evaluated per cycle:
//   1 Redirect: PC<=RedirectPC, InstrValid<=0. Current word is dropped with no RAS change. Applies even if Stall=1.
//   2 Stall: PC, outputs and RAS held. InstrValid unchanged.
//   3 PC>=IMEM_WORDS: Fault<=1, Halted<=1, InstrValid<=0.
//   4 InstrIn==32'hFFFF_FFFF (EXIT): Halted<=1, InstrValid<=0. PC holds.
//     Opcode 111111 with any other payload is DISPLAY: a normal sequential instruction.
//   5 op==6'b010011 and rs==5'b11111 (JR): pop RAS, PC<=popped value, forward instruction.
//     If RAS empty: Fault<=1, Halted<=1, InstrValid<=0.
//   6 op==6'b010011 with other rs (JAL): push PC+1, PC<={zero-ext imm}, forward with LinkAddr=PC+1.
//   7 otherwise: PC<=PC+1 (wraps modulo 2^ADDR_W), forward instruction.
//  Forward means InstrOut<=InstrIn, InstrPC<=PC, LinkAddr<=PC+1, InstrValid<=1.
//  Latency: word fetched at Addr=N appears on InstrOut the next cycle.
//  Throughput: one instruction per cycle, jumps included; no bubble on JAL/JR.
//  RAS: push onto full RAS overwrites the oldest entry (circular) and sets RasOverflow.
//  Depth count saturates at RAS_DEPTH. Push and pop never occur in the same cycle.
// STRUCTURE
//  Shared package (mips_pkg):
//   OP_JAL = 6'b010011, OP_DISP = 6'b111111, RA_FIELD = 5'b11111, EXIT_WORD = 32'hFFFF_FFFF
//   field-slice localparams
//   state enum {ST_RUN, ST_HALT}
//  Sub-module return_addr_stack (DEPTH, W):
//   inputs push, pop, din
//   outputs dout, empty, full, overflow_pulse
//   synchronous reset
// TESTING
//  1 Run the sample program at imem[0..7]:
//    Addr sequence 0,1,2,3,6,7,4,5, then Halted=1 with Addr stuck at 5.
//    JAL@3 gives LinkAddr=4. InstrValid never asserted for word 5.
//  2 Stall=1 for 3 cycles at PC=2 -> Addr stays 2, InstrOut/InstrPC unchanged.
//    On release, next InstrPC=2 then 3, no duplicate and no skip.
//  3 Redirect=1, RedirectPC=6, together with Stall=1 at PC=1 -> next Addr=6, InstrValid=0 for one cycle.
//  4 JR (32'h4FE0_0000) with empty RAS at PC=0 -> Fault=1, Halted=1, InstrValid=0, PC frozen.
//  5 Five nested JALs with RAS_DEPTH=4 -> RasOverflow=1 after the 5th.
//    Five JRs then return to the 4 newest link addresses; the 5th JR faults.
//  6 Rst for 1 cycle mid-program at PC=6 with RAS holding 4 -> Addr=0, all outputs 0.
//    A following JR faults, confirming the RAS was cleared.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, instruction field slices and fetch state encoding
package mips_pkg;
  localparam logic [5:0] OP_JAL = 6'b010011;
  localparam logic [5:0] OP_DISP = 6'b111111;
  localparam logic [4:0] RA_FIELD = 5'b11111;
  localparam logic [31:0] EXIT_WORD = {OP_DISP, 26'h3FF_FFFF};
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int IMM_HI = 10;
  localparam int IMM_LO = 0;
  typedef enum logic {ST_RUN, ST_HALT} state_t;
  function automatic logic is_exit(input logic [31:0] w);
    return w == EXIT_WORD;
  endfunction
endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack, oldest entry overwritten when full
module return_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         overflow_pulse
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  assign dout = mem[ptr - PW'(1)];
  assign overflow_pulse = push & full;
  always_ff @(posedge clk)
    if (push) mem[ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      cnt <= full ? cnt : cnt + CW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner resolving JAL/JR/EXIT at fetch with a RAS, honouring stalls and redirects
module fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RESET_PC = 0,
  parameter int IMEM_WORDS = 11,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr,
  input  logic [31:0]       instr_in,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] link_addr,
  output logic              halted,
  output logic              fault,
  output logic              ras_overflow
);
  state_t st, st_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, ras_dout;
  logic push, pop, fwd, valid_n, fault_n, op_j, is_jr;
  logic ras_empty, ras_full, ovf_pulse;
  assign addr = pc;
  assign halted = st == ST_HALT;
  assign pc_inc = pc + ADDR_W'(1);
  assign op_j = instr_in[OP_HI:OP_LO] == OP_JAL;
  assign is_jr = op_j && instr_in[RS_HI:RS_LO] == RA_FIELD;
  return_addr_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(pc_inc),
    .dout(ras_dout),
    .empty(ras_empty),
    .full(ras_full),
    .overflow_pulse(ovf_pulse)
  );
  always_comb begin
    st_n = st;
    pc_n = pc;
    valid_n = instr_valid;
    fault_n = fault;
    push = 1'b0;
    pop = 1'b0;
    fwd = 1'b0;
    if (st == ST_HALT) begin
      valid_n = 1'b0;
    end else if (redirect) begin
      pc_n = redirect_pc;
      valid_n = 1'b0;
    end else if (!stall) begin
      if (pc >= ADDR_W'(IMEM_WORDS) || (is_jr && ras_empty)) begin
        st_n = ST_HALT;
        fault_n = 1'b1;
        valid_n = 1'b0;
      end else if (is_exit(instr_in)) begin
        st_n = ST_HALT;
        valid_n = 1'b0;
      end else begin
        fwd = 1'b1;
        valid_n = 1'b1;
        pop = is_jr;
        push = op_j && !is_jr;
        pc_n = is_jr ? ras_dout : op_j ? ADDR_W'(instr_in[IMM_HI:IMM_LO]) : pc_inc;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_RUN;
      pc <= ADDR_W'(RESET_PC);
      instr_out <= '0;
      instr_pc <= '0;
      link_addr <= '0;
      instr_valid <= 1'b0;
      fault <= 1'b0;
      ras_overflow <= 1'b0;
    end else begin
      st <= st_n;
      pc <= pc_n;
      instr_valid <= valid_n;
      fault <= fault_n;
      ras_overflow <= ras_overflow | ovf_pulse;
      if (fwd) begin
        instr_out <= instr_in;
        instr_pc <= pc;
        link_addr <= pc_inc;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst) assert (!ovf_pulse || ras_full);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed programs with a scoreboard queue checked by an output monitor
module tb_fetch_unit;
  localparam logic [31:0] JR = 32'h4FE0_0000;
  localparam logic [31:0] JAL = 32'h4C00_0000;
  localparam logic [31:0] EXIT = 32'hFFFF_FFFF;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] link;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] addr, instr_in, instr_out, instr_pc, link_addr;
  logic instr_valid, halted, fault, ras_overflow;
  logic [31:0] imem [16];
  exp_t q[$];
  int n_pass = 0, n_total = 0;
  logic mon_s, mon_r;
  logic [31:0] seq1 [8] = '{0, 1, 2, 3, 6, 7, 4, 5};
  logic [31:0] seq5 [10] = '{0, 2, 4, 6, 8, 10, 9, 7, 5, 3};
  always #5 clk = ~clk;
  assign instr_in = addr < 32'd16 ? imem[addr[3:0]] : 32'h0;
  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .instr_in(instr_in),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr_out(instr_out),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .link_addr(link_addr),
    .halted(halted),
    .fault(fault),
    .ras_overflow(ras_overflow)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
  endtask
  task automatic expect_out(input logic [31:0] pc);
    q.push_back('{pc, imem[pc[3:0]], pc + 32'd1});
  endtask
  task automatic load_seq;
    for (int i = 0; i < 16; i++) imem[i] = 32'h0000_00A0 + i;
  endtask
  task automatic clear_mem;
    for (int i = 0; i < 16; i++) imem[i] = 32'h0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_instr_out"}, instr_out, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_link"}, link_addr, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_ovf"}, ras_overflow, 0);
  endtask
  task automatic chk_drained(input string tag);
    chk({tag, "_queue_left"}, q.size(), 0);
    q.delete();
  endtask
  always @(posedge clk) begin
    mon_s = stall;
    mon_r = rst;
    #1;
    if (instr_valid && !mon_s && !mon_r) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got pc=%0h instr=%0h, expected no output", instr_pc, instr_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_pc", instr_pc, e.pc);
        chk("out_instr", instr_out, e.instr);
        chk("out_link", link_addr, e.link);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    clear_mem();
    imem[0] = 32'h0000_0011;
    imem[1] = 32'h0000_0022;
    imem[2] = 32'hFC00_0001;
    imem[3] = JAL | 32'd6;
    imem[4] = 32'h0000_0044;
    imem[5] = EXIT;
    imem[6] = 32'h0000_0066;
    imem[7] = JR;
    @(negedge clk);
    do_reset();
    chk_reset_state("reset");
    foreach (seq1[i]) expect_out(seq1[i]);
    void'(q.pop_back());
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("prog_addr%0d", i), addr, seq1[i]);
      @(negedge clk);
    end
    chk("exit_halted", halted, 1);
    chk("exit_addr", addr, 5);
    chk("exit_valid", instr_valid, 0);
    chk("exit_fault", fault, 0);
    redirect = 1'b1;
    redirect_pc = 32'd2;
    @(negedge clk);
    redirect = 1'b0;
    chk("halt_ignores_redirect", addr, 5);
    chk("halt_valid", instr_valid, 0);
    chk_drained("prog");
    load_seq();
    do_reset();
    for (int i = 0; i < 4; i++) expect_out(i);
    @(negedge clk);
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_addr", addr, 2);
      chk("stall_pc", instr_pc, 1);
      chk("stall_instr", instr_out, 32'hA1);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("release_pc", instr_pc, 2);
    @(negedge clk);
    chk("release_next_pc", instr_pc, 3);
    chk_drained("stall");
    do_reset();
    expect_out(0);
    expect_out(6);
    @(negedge clk);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'd6;
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    chk("redir_addr", addr, 6);
    chk("redir_valid", instr_valid, 0);
    @(negedge clk);
    chk("redir_target_valid", instr_valid, 1);
    chk_drained("redirect");
    clear_mem();
    imem[0] = JR;
    do_reset();
    @(negedge clk);
    chk("jr_empty_fault", fault, 1);
    chk("jr_empty_halted", halted, 1);
    chk("jr_empty_valid", instr_valid, 0);
    @(negedge clk);
    chk("jr_empty_addr", addr, 0);
    clear_mem();
    imem[0] = JAL | 32'd2;
    imem[2] = JAL | 32'd4;
    imem[4] = JAL | 32'd6;
    imem[6] = JAL | 32'd8;
    imem[8] = JAL | 32'd10;
    imem[10] = JR;
    imem[9] = JR;
    imem[7] = JR;
    imem[5] = JR;
    imem[3] = JR;
    do_reset();
    for (int i = 0; i < 9; i++) expect_out(seq5[i]);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("ras_addr%0d", i), addr, seq5[i]);
      if (i == 4) chk("ovf_before_5th", ras_overflow, 0);
      if (i == 5) chk("ovf_after_5th", ras_overflow, 1);
      @(negedge clk);
    end
    chk("ras_5th_jr_fault", fault, 1);
    chk("ras_5th_jr_halted", halted, 1);
    chk("ras_5th_jr_addr", addr, 3);
    chk_drained("ras");
    clear_mem();
    imem[0] = JAL | 32'd1;
    imem[1] = JAL | 32'd2;
    imem[2] = JAL | 32'd3;
    imem[3] = JAL | 32'd6;
    imem[6] = 32'h0000_0066;
    do_reset();
    for (int i = 0; i < 4; i++) expect_out(i);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("mid_addr", addr, 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem[0] = JR;
    chk_reset_state("mid_reset");
    @(negedge clk);
    chk("ras_cleared_fault", fault, 1);
    chk("ras_cleared_halted", halted, 1);
    chk_drained("mid");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
